// File: rtl/proc_pkg.sv
// Shared types and constants for the processor and its instruction feeder.
package proc_pkg;

  localparam int DATA_W = 9;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_IMM,
    ST_WAIT,
    ST_HALT
  } feeder_state_t;

  function automatic logic [2:0] opcode(input logic [DATA_W-1:0] w);
    return w[2:0];
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: un-reset register array, synchronous write, two async reads.
module prog_mem
  import proc_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr0,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge Clock)
    if (we) mem[waddr] <= wdata;

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/instr_feeder.sv
// Sequencer driving the processor Run/DIN port from a loadable program store.
// Define FEEDER_LOOP_EN to wrap PC to 0 at end of program instead of halting.
module instr_feeder
  import proc_pkg::*;
#(
  parameter int  DEPTH   = 32,
  parameter int  TIMEOUT = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [AW:0]       ProgLen,
  input  logic              LoadEn,
  input  logic [AW-1:0]     LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
  input  logic              Done,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [AW-1:0]     PC,
  output logic [15:0]       InstrCount
);

  localparam int CW = $clog2(TIMEOUT + 1);

  feeder_state_t     state;
  logic [AW:0]       pc_q, len_q, pc_p1, pc_p2, pc_nxt;
  logic [CW-1:0]     wait_cnt;
  logic [DATA_W-1:0] rd0, rd1;
  logic              idle_like, is_halt, is_mvi, mvi_trunc, end_prog;

  // PC carries one extra bit so end-of-program compares work at len == DEPTH.
  assign pc_p1    = pc_q + 1'b1;
  assign pc_p2    = pc_q + (AW+1)'(2);
  assign pc_nxt   = (state == ST_IMM) ? pc_p2 : pc_p1;
  assign end_prog = pc_nxt >= len_q;

  assign idle_like = (state == ST_IDLE) || (state == ST_HALT);

  prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .Clock  (Clock),
    .we     (LoadEn && idle_like),
    .waddr  (LoadAddr),
    .wdata  (LoadData),
    .raddr0 (pc_q[AW-1:0]),
    .raddr1 (pc_p1[AW-1:0]),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  assign is_halt   = opcode(rd0) == OP_HALT;
  assign is_mvi    = opcode(rd0) == OP_MVI;
  assign mvi_trunc = is_mvi && (pc_p1 >= len_q);

  assign Run    = (state == ST_ISSUE) && !is_halt && !mvi_trunc;
  assign Busy   = (state == ST_ISSUE) || (state == ST_IMM) || (state == ST_WAIT);
  assign Halted = state == ST_HALT;
  assign PC     = pc_q[AW-1:0];

  // Outside the active states DIN is forced to zero since the array has no reset.
  always_comb begin
    DIN = '0;
    case (state)
      ST_ISSUE, ST_WAIT: DIN = rd0;
      ST_IMM:            DIN = rd1;
      default:           DIN = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= ST_IDLE;
      pc_q       <= '0;
      len_q      <= '0;
      wait_cnt   <= '0;
      Error      <= 1'b0;
      InstrCount <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (Start) begin
            len_q      <= ProgLen;
            pc_q       <= '0;
            Error      <= 1'b0;
            InstrCount <= '0;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          if (is_halt)
            state <= ST_HALT;
          else if (mvi_trunc) begin
            Error <= 1'b1;
            state <= ST_HALT;
          end else if (is_mvi)
            state <= ST_IMM;
          else
            state <= ST_WAIT;
        end
        ST_IMM, ST_WAIT: begin
          if (Done) begin
            if (InstrCount != 16'hFFFF) InstrCount <= InstrCount + 16'd1;
`ifdef FEEDER_LOOP_EN
            pc_q  <= end_prog ? '0 : pc_nxt;
            state <= ST_ISSUE;
`else
            pc_q  <= pc_nxt;
            state <= end_prog ? ST_HALT : ST_ISSUE;
`endif
          end else if (state == ST_IMM || wait_cnt == CW'(TIMEOUT - 1)) begin
            // The immediate cycle must complete; a missing Done there is fatal.
            Error <= 1'b1;
            state <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder with a small processor Done model and a DIN scoreboard.
module tb_instr_feeder;
  import proc_pkg::*;

  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic              Clock = 1'b0;
  logic              Resetn;
  logic              Start;
  logic [AW:0]       ProgLen;
  logic              LoadEn;
  logic [AW-1:0]     LoadAddr;
  logic [DATA_W-1:0] LoadData;
  logic              Done;
  logic [DATA_W-1:0] DIN;
  logic              Run, Busy, Halted, Error;
  logic [AW-1:0]     PC;
  logic [15:0]       InstrCount;

  int checks = 0;
  int errors = 0;

  instr_feeder #(.DEPTH(DEPTH), .TIMEOUT(8)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .ProgLen(ProgLen),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData), .Done(Done),
    .DIN(DIN), .Run(Run), .Busy(Busy), .Halted(Halted), .Error(Error),
    .PC(PC), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  // Processor step model: mv/mvi finish in T1, add/sub in T3.
  logic [2:0] tstep, top;
  logic       done_kill;
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tstep <= 3'd0;
      top   <= 3'd0;
    end else if (Run) begin
      tstep <= 3'd1;
      top   <= DIN[2:0];
    end else if (Done) begin
      tstep <= 3'd0;
    end else if (tstep != 3'd0 && tstep != 3'd7) begin
      tstep <= tstep + 3'd1;
    end
  end
  assign Done = !done_kill && tstep != 3'd0 &&
                tstep == ((top == OP_ADD || top == OP_SUB) ? 3'd3 : 3'd1);

  // Monitor: every issued word with the cycle it was issued in.
  int unsigned       cyc = 0;
  logic [DATA_W-1:0] obs_din[$];
  int unsigned       obs_t[$];
  always @(negedge Clock) begin
    cyc <= cyc + 1;
    if (Run) begin
      obs_din.push_back(DIN);
      obs_t.push_back(cyc);
    end
  end

  logic [DATA_W-1:0] exp_q[$];
  int                rd_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [DATA_W-1:0] e;
    chk({tag, "_runs"}, obs_din.size() - rd_idx, exp_q.size());
    while (exp_q.size() > 0 && rd_idx < obs_din.size()) begin
      e = exp_q.pop_front();
      chk({tag, "_din"}, obs_din[rd_idx], e);
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = obs_din.size();
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    @(negedge Clock);
    LoadEn = 1'b0;
  endtask

  task automatic start(input logic [AW:0] len);
    Start = 1'b1; ProgLen = len;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!Halted && n < 100) begin
      @(negedge Clock);
      n++;
    end
    chk(tag, Halted, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b0; Start = 1'b0; ProgLen = '0; LoadEn = 1'b0;
    LoadAddr = '0; LoadData = '0; done_kill = 1'b0;
    repeat (2) @(negedge Clock);

    chk("rst_run",   Run, 1'b0);
    chk("rst_din",   DIN, 9'h000);
    chk("rst_busy",  Busy, 1'b0);
    chk("rst_halt",  Halted, 1'b0);
    chk("rst_err",   Error, 1'b0);
    chk("rst_pc",    PC, 0);
    chk("rst_count", InstrCount, 0);
    Resetn = 1'b1;
    @(negedge Clock);

`ifndef FEEDER_LOOP_EN
    // mvi with immediate in the following cycle
    load(0, 9'h001); load(1, 9'h005);
    exp_q.push_back(9'h001);
    start(2);
    chk("mvi_run",  Run, 1'b1);
    chk("mvi_op",   DIN, 9'h001);
    @(negedge Clock);
    chk("mvi_imm_run", Run, 1'b0);
    chk("mvi_imm",  DIN, 9'h005);
    @(negedge Clock);
    chk("mvi_halt", Halted, 1'b1);
    chk("mvi_cnt",  InstrCount, 1);
    chk("mvi_err",  Error, 1'b0);
    chk("mvi_pc",   PC, 2);
    sb_check("mvi");

    // mv, add, sub, mv: Run spacing 2, 4, 4
    load(0, 9'h040); load(1, 9'h00A); load(2, 9'h043); load(3, 9'h080);
    exp_q.push_back(9'h040); exp_q.push_back(9'h00A);
    exp_q.push_back(9'h043); exp_q.push_back(9'h080);
    start(4);
    wait_halt("seq_halt");
    chk("seq_gap0", obs_t[rd_idx+1] - obs_t[rd_idx],   2);
    chk("seq_gap1", obs_t[rd_idx+2] - obs_t[rd_idx+1], 4);
    chk("seq_gap2", obs_t[rd_idx+3] - obs_t[rd_idx+2], 4);
    chk("seq_cnt",  InstrCount, 4);
    chk("seq_pc",   PC, 4);
    chk("seq_err",  Error, 1'b0);
    sb_check("seq");

    // HALT word at address 1
    load(0, 9'h040); load(1, 9'h007);
    exp_q.push_back(9'h040);
    start(5);
    wait_halt("hw_halt");
    chk("hw_pc",  PC, 1);
    chk("hw_cnt", InstrCount, 1);
    chk("hw_err", Error, 1'b0);
    sb_check("hw");

    // Done stuck low: timeout after 8 WAIT cycles
    load(0, 9'h00A);
    done_kill = 1'b1;
    exp_q.push_back(9'h00A);
    start(1);
    for (int i = 0; i < 8; i++) @(negedge Clock);
    chk("to_busy", Busy, 1'b1);
    chk("to_err0", Error, 1'b0);
    @(negedge Clock);
    chk("to_halt", Halted, 1'b1);
    chk("to_err",  Error, 1'b1);
    chk("to_cnt",  InstrCount, 0);
    done_kill = 1'b0;
    sb_check("to");
    load(0, 9'h040);
    exp_q.push_back(9'h040);
    start(1);
    chk("to_clr", Error, 1'b0);
    wait_halt("to_rerun");
    sb_check("to_rerun");

    // mvi truncated by end of program
    load(0, 9'h001);
    start(1);
    chk("tr_run",  Run, 1'b0);
    @(negedge Clock);
    chk("tr_halt", Halted, 1'b1);
    chk("tr_err",  Error, 1'b1);
    chk("tr_cnt",  InstrCount, 0);
    sb_check("tr");

    // Load and Start in the same cycle: first issue sees the new word
    LoadEn = 1'b1; LoadAddr = 0; LoadData = 9'h040; Start = 1'b1; ProgLen = 1;
    @(negedge Clock);
    LoadEn = 1'b0; Start = 1'b0;
    exp_q.push_back(9'h040);
    chk("ls_run", Run, 1'b1);
    chk("ls_din", DIN, 9'h040);
    wait_halt("ls_halt");
    chk("ls_cnt", InstrCount, 1);
    sb_check("ls");
`else
    // Looping 2-word program
    load(0, 9'h040); load(1, 9'h080);
    start(2);
    for (int k = 0; k < 6; k++) begin
      chk("lp_pc",  PC, k % 2);
      chk("lp_cnt", InstrCount, k);
      chk("lp_run", Run, 1'b1);
      exp_q.push_back((k % 2) ? 9'h080 : 9'h040);
      repeat (2) @(negedge Clock);
    end
    Resetn = 1'b0;
    #1;
    Resetn = 1'b1;
    sb_check("lp");
    @(negedge Clock);
`endif

    // Asynchronous reset in the middle of an add
    load(0, 9'h040); load(1, 9'h00A); load(2, 9'h043); load(3, 9'h080);
    exp_q.push_back(9'h040); exp_q.push_back(9'h00A);
    start(4);
    repeat (3) @(negedge Clock);
    chk("mr_pc_pre", PC, 1);
    #2 Resetn = 1'b0;
    #1;
    chk("mr_run",   Run, 1'b0);
    chk("mr_din",   DIN, 9'h000);
    chk("mr_busy",  Busy, 1'b0);
    chk("mr_halt",  Halted, 1'b0);
    chk("mr_err",   Error, 1'b0);
    chk("mr_pc",    PC, 0);
    chk("mr_count", InstrCount, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    sb_check("mr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
